// File: rtl/collision_checker.sv
// collision_checker
//   Frame-based collision / eating checker for the snake game. During a video
//   frame it counts pixels where the snake head overlaps each food object, the
//   wall and the snake body. One cycle after the frame ends it reports at most
//   one event: a bump (game over) or an eat carrying the index of the food.
//   A saturating score counts eats since the last clear.
//
//   Handshake: there is no valid/ready flow control. frame_start_i and
//   frame_end_i are single-cycle strobes. Pixel inputs are sampled only while
//   pix_valid_i is high. eat_pulse_o and bump_pulse_o are single-cycle
//   strobes, and the consumer must take them in the cycle they are high.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   frame_start_i  pulse before the first active pixel
//   frame_end_i    pulse on/after the last active pixel (that pixel still counts)
//   pix_valid_i    pixel inputs valid
//   snake_head_i   pixel is snake head
//   snake_body_i   pixel is snake body
//   food_i         bit i: pixel is food i
//   boundary_i     pixel is wall
//   clear_i        synchronous game restart, highest priority
//   eat_pulse_o    food eaten this frame (one cycle)
//   eat_idx_o      index of last eaten food
//   bump_pulse_o   collision this frame (one cycle)
//   game_over_o    sticky collision flag
//   score_o        saturating eat count
//   in_frame_o     high while scanning a frame
//   state_o        current FSM state, for debug and checkers
module collision_checker #(
  parameter int NUM_FOOD    = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 8,
  parameter int OVERLAP_MIN = 4,
  parameter int SCORE_W     = 8,
  parameter int WRAP_MODE   = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_start_i,
  input  logic                frame_end_i,
  input  logic                pix_valid_i,
  input  logic                snake_head_i,
  input  logic                snake_body_i,
  input  logic [NUM_FOOD-1:0] food_i,
  input  logic                boundary_i,
  input  logic                clear_i,
  output logic                eat_pulse_o,
  output logic [IDX_W-1:0]    eat_idx_o,
  output logic                bump_pulse_o,
  output logic                game_over_o,
  output logic [SCORE_W-1:0]  score_o,
  output logic                in_frame_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EVAL = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(OVERLAP_MIN);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   food_cnt_q [NUM_FOOD];
  logic [CNT_W-1:0]   food_cnt_d [NUM_FOOD];
  logic [CNT_W-1:0]   bnd_cnt_q, bnd_cnt_d;
  logic [CNT_W-1:0]   body_cnt_q, body_cnt_d;
  logic               eat_pulse_q, eat_pulse_d;
  logic               bump_pulse_q, bump_pulse_d;
  logic [IDX_W-1:0]   eat_idx_q, eat_idx_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;

  // Frame verdict, derived only from the counter registers so that the EVAL
  // cycle sees the completed frame.
  logic             bump_hit;
  logic             food_hit;
  logic [IDX_W-1:0] food_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    bump_hit = (body_cnt_q >= MIN_C) || ((WRAP_MODE == 0) && (bnd_cnt_q >= MIN_C));
    food_hit = 1'b0;
    food_sel = '0;
    // Walk downwards so the lowest matching index is the one that remains.
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (food_cnt_q[i] >= MIN_C) begin
        food_hit = 1'b1;
        food_sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    food_cnt_d   = food_cnt_q;
    bnd_cnt_d    = bnd_cnt_q;
    body_cnt_d   = body_cnt_q;
    eat_pulse_d  = 1'b0;
    bump_pulse_d = 1'b0;
    eat_idx_d    = eat_idx_q;
    game_over_d  = game_over_q;
    score_d      = score_q;

    if (clear_i) begin
      state_d     = IDLE;
      for (int i = 0; i < NUM_FOOD; i++) food_cnt_d[i] = '0;
      bnd_cnt_d   = '0;
      body_cnt_d  = '0;
      eat_idx_d   = '0;
      game_over_d = 1'b0;
      score_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            state_d    = SCAN;
            for (int i = 0; i < NUM_FOOD; i++) food_cnt_d[i] = '0;
            bnd_cnt_d  = '0;
            body_cnt_d = '0;
          end
        end
        SCAN: begin
          if (frame_start_i && !frame_end_i) begin
            // Aborted frame: restart the count and keep scanning.
            for (int i = 0; i < NUM_FOOD; i++) food_cnt_d[i] = '0;
            bnd_cnt_d  = '0;
            body_cnt_d = '0;
          end else begin
            // The pixel in the frame_end cycle is still part of the frame.
            if (pix_valid_i && snake_head_i) begin
              for (int i = 0; i < NUM_FOOD; i++) begin
                if (food_i[i]) food_cnt_d[i] = sat_inc(food_cnt_q[i]);
              end
              if (boundary_i)   bnd_cnt_d  = sat_inc(bnd_cnt_q);
              if (snake_body_i) body_cnt_d = sat_inc(body_cnt_q);
            end
            if (frame_end_i) state_d = EVAL;
          end
        end
        EVAL: begin
          if (bump_hit) begin
            bump_pulse_d = 1'b1;
            game_over_d  = 1'b1;
            state_d      = OVER;
          end else begin
            if (food_hit) begin
              eat_pulse_d = 1'b1;
              eat_idx_d   = food_sel;
              score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            end
            state_d = IDLE;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_FOOD; i++) food_cnt_q[i] <= '0;
      bnd_cnt_q    <= '0;
      body_cnt_q   <= '0;
      eat_pulse_q  <= 1'b0;
      bump_pulse_q <= 1'b0;
      eat_idx_q    <= '0;
      game_over_q  <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      food_cnt_q   <= food_cnt_d;
      bnd_cnt_q    <= bnd_cnt_d;
      body_cnt_q   <= body_cnt_d;
      eat_pulse_q  <= eat_pulse_d;
      bump_pulse_q <= bump_pulse_d;
      eat_idx_q    <= eat_idx_d;
      game_over_q  <= game_over_d;
      score_q      <= score_d;
    end
  end

  assign eat_pulse_o  = eat_pulse_q;
  assign bump_pulse_o = bump_pulse_q;
  assign eat_idx_o    = eat_idx_q;
  assign game_over_o  = game_over_q;
  assign score_o      = score_q;
  assign in_frame_o   = (state_q == SCAN);
  assign state_o      = state_q;

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker. Three instances share the pixel bus:
//   0: default parameters, 1: WRAP_MODE=1, 2: SCORE_W=2 / CNT_W=3.
// Frame strobes and clear are gated per instance so only the selected one
// sees a frame.
module tb_collision_checker;

  localparam int MIN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] en;
  logic       frame_start, frame_end, clear;
  logic       pix_valid, head, body, bnd;
  logic [3:0] food;

  logic       eat_p  [3];
  logic       bump_p [3];
  logic       go     [3];
  logic       inf    [3];
  logic [1:0] idx    [3];
  logic [1:0] st     [3];
  logic [7:0] score_m, score_w;
  logic [1:0] score_s;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {bump, eat, idx[1:0], game_over, score[7:0]}
  logic [12:0] exp_q[$];
  int          exp_score [3];
  logic [1:0]  exp_idx   [3];
  logic        exp_go    [3];
  int          wrap_of   [3] = '{0, 1, 0};
  int          smax      [3] = '{255, 255, 3};

  int eat_cnt  [3] = '{0, 0, 0};
  int bump_cnt [3] = '{0, 0, 0};

  collision_checker #(
    .NUM_FOOD(4), .IDX_W(2), .CNT_W(8), .OVERLAP_MIN(4), .SCORE_W(8), .WRAP_MODE(0)
  ) u_main (
    .clk_i(clk), .rst_ni(rst_n),
    .frame_start_i(frame_start & en[0]), .frame_end_i(frame_end & en[0]),
    .pix_valid_i(pix_valid), .snake_head_i(head), .snake_body_i(body),
    .food_i(food), .boundary_i(bnd), .clear_i(clear & en[0]),
    .eat_pulse_o(eat_p[0]), .eat_idx_o(idx[0]), .bump_pulse_o(bump_p[0]),
    .game_over_o(go[0]), .score_o(score_m), .in_frame_o(inf[0]), .state_o(st[0])
  );

  collision_checker #(
    .NUM_FOOD(4), .IDX_W(2), .CNT_W(8), .OVERLAP_MIN(4), .SCORE_W(8), .WRAP_MODE(1)
  ) u_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .frame_start_i(frame_start & en[1]), .frame_end_i(frame_end & en[1]),
    .pix_valid_i(pix_valid), .snake_head_i(head), .snake_body_i(body),
    .food_i(food), .boundary_i(bnd), .clear_i(clear & en[1]),
    .eat_pulse_o(eat_p[1]), .eat_idx_o(idx[1]), .bump_pulse_o(bump_p[1]),
    .game_over_o(go[1]), .score_o(score_w), .in_frame_o(inf[1]), .state_o(st[1])
  );

  collision_checker #(
    .NUM_FOOD(4), .IDX_W(2), .CNT_W(3), .OVERLAP_MIN(4), .SCORE_W(2), .WRAP_MODE(0)
  ) u_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .frame_start_i(frame_start & en[2]), .frame_end_i(frame_end & en[2]),
    .pix_valid_i(pix_valid), .snake_head_i(head), .snake_body_i(body),
    .food_i(food), .boundary_i(bnd), .clear_i(clear & en[2]),
    .eat_pulse_o(eat_p[2]), .eat_idx_o(idx[2]), .bump_pulse_o(bump_p[2]),
    .game_over_o(go[2]), .score_o(score_s), .in_frame_o(inf[2]), .state_o(st[2])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (eat_p[k])  eat_cnt[k]  <= eat_cnt[k] + 1;
      if (bump_p[k]) bump_cnt[k] <= bump_cnt[k] + 1;
    end
  end

  function automatic logic [7:0] get_score(input int d);
    if (d == 0) return score_m;
    if (d == 1) return score_w;
    return {6'b0, score_s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; frame_end = 1'b0; clear = 1'b0;
    pix_valid = 1'b0; head = 1'b0; body = 1'b0; bnd = 1'b0; food = 4'h0;
  endtask

  task automatic select(input int d);
    en = 3'(1 << d);
  endtask

  task automatic begin_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_pix(input int n, input logic b, input logic [3:0] f, input logic w);
    repeat (n) begin
      pix_valid = 1'b1; head = 1'b1; body = b; food = f; bnd = w;
      tick();
    end
    idle_inputs();
  endtask

  // Pixels that must never count: not head, or head outside valid video.
  task automatic noise(input int n);
    repeat (n) begin
      pix_valid = 1'($urandom_range(0, 1));
      head      = ~pix_valid;
      body      = 1'($urandom_range(0, 1));
      bnd       = 1'($urandom_range(0, 1));
      food      = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
  endtask

  task automatic end_frame(input logic with_pix, input logic [3:0] f, input logic also_start);
    frame_end = 1'b1; frame_start = also_start;
    pix_valid = with_pix; head = with_pix; food = with_pix ? f : 4'h0;
    tick();
    idle_inputs();
  endtask

  // ---------------- model / scoreboard ----------------
  task automatic predict(input int d, input int f0, input int f1, input int f2, input int f3,
                         input int nbody, input int nbnd);
    int   fc[4];
    int   sel;
    logic bmp;
    fc  = '{f0, f1, f2, f3};
    sel = -1;
    bmp = (nbody >= MIN) || ((wrap_of[d] == 0) && (nbnd >= MIN));
    for (int i = 3; i >= 0; i--) if (fc[i] >= MIN) sel = i;
    if (exp_go[d]) begin
      exp_q.push_back({2'b00, exp_idx[d], 1'b1, 8'(exp_score[d])});
    end else if (bmp) begin
      exp_go[d] = 1'b1;
      exp_q.push_back({2'b10, exp_idx[d], 1'b1, 8'(exp_score[d])});
    end else if (sel >= 0) begin
      exp_idx[d]   = 2'(sel);
      exp_score[d] = (exp_score[d] >= smax[d]) ? smax[d] : exp_score[d] + 1;
      exp_q.push_back({2'b01, exp_idx[d], 1'b0, 8'(exp_score[d])});
    end else begin
      exp_q.push_back({2'b00, exp_idx[d], exp_go[d], 8'(exp_score[d])});
    end
  endtask

  // Called right after end_frame (edge k + 1ns). Optionally drives a
  // frame_start during the EVAL cycle, which must be dropped.
  task automatic expect_event(input int d, input logic poke_start);
    logic [12:0] exp;
    logic [12:0] obs;
    exp = exp_q.pop_front();
    if (poke_start) frame_start = 1'b1;
    @(negedge clk);
    checks++;
    if (eat_p[d] !== 1'b0 || bump_p[d] !== 1'b0) begin
      failures++;
      $display("FAIL early_pulse dut=%0d eat=%b bump=%b required 0/0", d, eat_p[d], bump_p[d]);
    end
    @(negedge clk);
    frame_start = 1'b0;
    obs = {bump_p[d], eat_p[d], idx[d], go[d], get_score(d)};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL event dut=%0d got bump=%b eat=%b idx=%0d go=%b score=%0d required bump=%b eat=%b idx=%0d go=%b score=%0d",
               d, obs[12], obs[11], obs[10:9], obs[8], obs[7:0],
               exp[12], exp[11], exp[10:9], exp[8], exp[7:0]);
    end
    @(negedge clk);
    checks++;
    if (eat_p[d] !== 1'b0 || bump_p[d] !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width dut=%0d eat=%b bump=%b required 0/0", d, eat_p[d], bump_p[d]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    en = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      exp_score[d] = 0; exp_idx[d] = 2'd0; exp_go[d] = 1'b0;
      checks++;
      if ({eat_p[d], bump_p[d], go[d], inf[d], idx[d], st[d], get_score(d)} !== 15'd0) begin
        failures++;
        $display("FAIL reset dut=%0d eat=%b bump=%b go=%b in_frame=%b idx=%0d state=%0d score=%0d required all 0",
                 d, eat_p[d], bump_p[d], go[d], inf[d], idx[d], st[d], get_score(d));
      end
    end
    tick();
  endtask

  task automatic test_eat_threshold();
    select(0);
    begin_frame();
    checks++;
    if (inf[0] !== 1'b1) begin
      failures++;
      $display("FAIL in_frame_rise got %b required 1", inf[0]);
    end
    noise(3);
    send_pix(4, 1'b0, 4'b0100, 1'b0);
    noise(2);
    end_frame(1'b0, 4'h0, 1'b0);
    checks++;
    if (inf[0] !== 1'b0) begin
      failures++;
      $display("FAIL in_frame_fall got %b required 0", inf[0]);
    end
    predict(0, 0, 0, 4, 0, 0, 0);
    expect_event(0, 1'b0);
    // One short of the threshold.
    begin_frame();
    send_pix(3, 1'b0, 4'b0100, 1'b0);
    noise(4);
    end_frame(1'b0, 4'h0, 1'b0);
    predict(0, 0, 0, 3, 0, 0, 0);
    expect_event(0, 1'b0);
    // Threshold reached by the pixel in the frame_end cycle.
    begin_frame();
    send_pix(3, 1'b0, 4'b0100, 1'b0);
    end_frame(1'b1, 4'b0100, 1'b0);
    predict(0, 0, 0, 4, 0, 0, 0);
    expect_event(0, 1'b0);
  endtask

  task automatic test_priority();
    select(0);
    begin_frame();
    send_pix(5, 1'b0, 4'b1010, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    predict(0, 0, 5, 0, 5, 0, 0);
    expect_event(0, 1'b0);
    begin_frame();
    send_pix(5, 1'b0, 4'b0010, 1'b0);
    send_pix(5, 1'b0, 4'b1000, 1'b0);
    send_pix(4, 1'b1, 4'b0000, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    predict(0, 0, 5, 0, 5, 4, 0);
    expect_event(0, 1'b0);
  endtask

  task automatic test_sticky_clear();
    int e0, b0;
    select(0);
    e0 = eat_cnt[0]; b0 = bump_cnt[0];
    repeat (3) begin
      begin_frame();
      send_pix(4, 1'b0, 4'b0001, 1'b0);
      end_frame(1'b0, 4'h0, 1'b0);
      predict(0, 4, 0, 0, 0, 0, 0);
      expect_event(0, 1'b0);
    end
    checks++;
    if (eat_cnt[0] !== e0 || bump_cnt[0] !== b0) begin
      failures++;
      $display("FAIL over_pulses eat=%0d bump=%0d required %0d/%0d", eat_cnt[0], bump_cnt[0], e0, b0);
    end
    // clear outranks a simultaneous frame_start.
    clear = 1'b1; frame_start = 1'b1;
    tick();
    idle_inputs();
    exp_go[0] = 1'b0; exp_score[0] = 0; exp_idx[0] = 2'd0;
    checks++;
    if ({go[0], score_m, idx[0], inf[0]} !== 12'd0) begin
      failures++;
      $display("FAIL clear go=%b score=%0d idx=%0d in_frame=%b required 0", go[0], score_m, idx[0], inf[0]);
    end
    tick();
    begin_frame();
    send_pix(4, 1'b0, 4'b0100, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    predict(0, 0, 0, 4, 0, 0, 0);
    expect_event(0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int d = 0; d < 2; d++) begin
      select(d);
      begin_frame();
      noise(2);
      send_pix(10, 1'b0, 4'b0000, 1'b1);
      end_frame(1'b0, 4'h0, 1'b0);
      predict(d, 0, 0, 0, 0, 0, 10);
      expect_event(d, 1'b0);
    end
  endtask

  task automatic test_saturation();
    select(2);
    repeat (5) begin
      begin_frame();
      send_pix(4, 1'b0, 4'b0001, 1'b0);
      end_frame(1'b0, 4'h0, 1'b0);
      predict(2, 4, 0, 0, 0, 0, 0);
      expect_event(2, 1'b0);
    end
    begin_frame();
    send_pix(20, 1'b0, 4'b1000, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    checks++;
    if (u_sat.food_cnt_q[3] !== 3'd7) begin
      failures++;
      $display("FAIL cnt_sat got %0d required 7", u_sat.food_cnt_q[3]);
    end
    predict(2, 0, 0, 0, 20, 0, 0);
    expect_event(2, 1'b0);
  endtask

  task automatic test_abort();
    select(0);
    clear = 1'b1;
    tick();
    idle_inputs();
    exp_go[0] = 1'b0; exp_score[0] = 0; exp_idx[0] = 2'd0;
    begin_frame();
    send_pix(3, 1'b0, 4'b0010, 1'b0);
    begin_frame();
    checks++;
    if (inf[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_scan got in_frame=%b required 1", inf[0]);
    end
    send_pix(1, 1'b0, 4'b0010, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    predict(0, 0, 1, 0, 0, 0, 0);
    expect_event(0, 1'b0);
    // frame_start together with frame_end: the end wins and its pixel counts.
    // A frame_start during EVAL is then dropped.
    begin_frame();
    send_pix(3, 1'b0, 4'b0010, 1'b0);
    end_frame(1'b1, 4'b0010, 1'b1);
    predict(0, 0, 4, 0, 0, 0, 0);
    expect_event(0, 1'b1);
    checks++;
    if (inf[0] !== 1'b0 || st[0] !== 2'd0) begin
      failures++;
      $display("FAIL eval_start_drop in_frame=%b state=%0d required 0/0", inf[0], st[0]);
    end
  endtask

  task automatic test_reset_eval();
    int e0, b0;
    select(0);
    begin_frame();
    send_pix(4, 1'b0, 4'b1000, 1'b0);
    end_frame(1'b0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({eat_p[0], bump_p[0], go[0], inf[0], idx[0], st[0], score_m} !== 15'd0) begin
      failures++;
      $display("FAIL reset_eval eat=%b bump=%b go=%b in_frame=%b idx=%0d state=%0d score=%0d required all 0",
               eat_p[0], bump_p[0], go[0], inf[0], idx[0], st[0], score_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e0 = eat_cnt[0]; b0 = bump_cnt[0];
    repeat (4) tick();
    for (int d = 0; d < 3; d++) begin
      exp_score[d] = 0; exp_idx[d] = 2'd0; exp_go[d] = 1'b0;
    end
    checks++;
    if (eat_cnt[0] !== e0 || bump_cnt[0] !== b0 || score_m !== 8'd0) begin
      failures++;
      $display("FAIL reset_release eat=%0d bump=%0d score=%0d required %0d/%0d/0",
               eat_cnt[0], bump_cnt[0], score_m, e0, b0);
    end
  endtask

  initial begin
    test_reset();
    test_eat_threshold();
    test_priority();
    test_sticky_clear();
    test_wrap();
    test_saturation();
    test_abort();
    test_reset_eval();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_checker.md
# collision_checker

Frame-based collision and eating checker for the snake game, successor to the single-pixel checker. It sits between the pixel/object generators and the game controller. During each video frame it counts head-overlap pixels against NUM_FOOD independent food objects, the boundary and the snake body. At frame end it reports at most one event: bump (game over) or eat with the food index. It also keeps a saturating score.

## Interface
- NUM_FOOD, 4: number of independent food channels (1..16)
- IDX_W, 2: width of eat_idx; must satisfy 2^IDX_W >= NUM_FOOD
- CNT_W, 8: width of each per-frame overlap counter
- OVERLAP_MIN, 4: overlap pixels required to trigger an event (1 .. 2^CNT_W-1)
- SCORE_W, 8: score width
- WRAP_MODE, 0: 0 = boundary overlap bumps; 1 = boundary overlap ignored (wrap-around playfield)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse before the first active pixel
- frame_end  in  1  one-cycle pulse after the last active pixel
- pix_valid  in  1  current pixel inputs valid (active video)
- snake_head  in  1  current pixel belongs to the head
- snake_body  in  1  current pixel belongs to the body
- food  in  NUM_FOOD  bit i = pixel belongs to food i
- boundary  in  1  current pixel belongs to the wall
- clear  in  1  synchronous game restart
- eat_pulse  out  1  one-cycle pulse: food eaten this frame
- eat_idx  out  IDX_W  index of eaten food; valid with eat_pulse, held until next eat
- bump_pulse  out  1  one-cycle pulse: collision this frame
- game_over  out  1  sticky; set with bump_pulse, cleared by clear or reset
- score  out  SCORE_W  eats since clear, saturating
- in_frame  out  1  high while in SCAN

## Operation
- States: IDLE, SCAN, EVAL, OVER.
- IDLE: frame_start moves to SCAN and zeroes all counters. frame_end is ignored.
- SCAN: on each cycle with pix_valid and snake_head, increment food_cnt[i] for every set food[i], bnd_cnt if boundary, body_cnt if snake_body. Counters saturate at 2^CNT_W-1. Several counters may increment in the same cycle.
- SCAN, frame_start again: the frame is aborted. Counters zero, state stays SCAN, no event.
- SCAN, frame_end: go to EVAL. The pixel presented in the frame_end cycle is still counted.
- SCAN, frame_start and frame_end in the same cycle: frame_end wins. frame_start is dropped.
- EVAL (exactly one cycle), evaluated in this priority order:
  - Bump condition: body_cnt >= OVERLAP_MIN, or (WRAP_MODE==0 and bnd_cnt >= OVERLAP_MIN).
  - If bump: assert bump_pulse, set game_over, go to OVER. No eat is reported, even if food overlapped.
  - Else, if any food_cnt[i] >= OVERLAP_MIN: take the lowest such i. Assert eat_pulse, load eat_idx=i, increment score (saturating at 2^SCORE_W-1). Go to IDLE.
  - Else go to IDLE with no pulse.
- OVER: all frame inputs are ignored. Outputs hold and no pulses are generated.
- clear (any state): next state IDLE. Counters, score, game_over and eat_idx go to 0. Pending pulses are suppressed. clear has priority over every other input.

## Timing
- Reset (rst low, asynchronous): state IDLE, all counters 0. eat_pulse=0, bump_pulse=0, game_over=0, score=0, eat_idx=0, in_frame=0.
- Reset is released synchronously by the integrator; the block needs no internal synchroniser.
- Latency: frame_end is sampled at edge k, the state is EVAL after edge k. eat_pulse or bump_pulse is high for exactly one cycle after edge k+1, two cycles after the frame_end cycle.
- score and game_over update on the same edge that raises the pulse.
- in_frame goes high on the edge after frame_start and low on the edge after frame_end.
- All outputs are registered. There are no combinational input-to-output paths.
- A new frame_start arriving while in EVAL is dropped. The next frame must start at least 2 cycles after frame_end.

## Test plan
- Eat with threshold (OVERLAP_MIN=4, NUM_FOOD=4): a frame with 4 head&food[2] pixels -> eat_pulse once, 2 cycles after frame_end, eat_idx=2, score 0->1. A frame with 3 overlap pixels -> no pulse, score unchanged.
- Priority and multiple food: one frame with 5 head&food[1] and 5 head&food[3] pixels -> eat_idx=1, score+1. Add 4 head&snake_body pixels in the same frame -> bump_pulse only, game_over=1, score unchanged.
- Wrap mode: 10 head&boundary pixels with WRAP_MODE=0 -> bump_pulse, game_over=1. Same stimulus with WRAP_MODE=1 -> no pulse, game_over=0.
- Sticky game over and clear: after a bump, run three frames with food overlap -> no pulses, score frozen. Pulse clear -> game_over=0, score=0. Next eating frame -> score=1.
- Saturation (SCORE_W=2, CNT_W=3): 5 eating frames -> score stays 3. 20 overlap pixels in one frame -> counter held at 7 and an eat is still reported.
- Abort and reset: frame_start mid-SCAN after 3 overlap pixels, then a frame with 1 overlap pixel -> no eat. Drop rst low in the middle of EVAL -> outputs 0 immediately and no pulse after release.
